// File: rtl/operand2_imm_encoder_pkg.sv
// Shared types and field widths for the operand-2 immediate encoder.
package operand2_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } enc_state_t;

    localparam int ROT_STEPS = 16;
    localparam int ROT_W     = 4;
    localparam int IMM_W     = 8;
    localparam int SRC2_W    = 12;

endpackage

// File: rtl/operand2_imm_encoder_rol_fit_check.sv
// Rotates a word left by 2*rot and reports whether the result fits in imm8.
module rol_fit_check
    import operand2_pkg::*;
(
    input  logic [31:0]      word,
    input  logic [ROT_W-1:0] rot,
    output logic             fit,
    output logic [IMM_W-1:0] imm8
);

    logic [4:0]  sh;
    logic [63:0] dbl;
    logic [31:0] rolled;

    // Doubling the word makes the upper half of the left shift a 32-bit rotate.
    always_comb begin
        sh     = {rot, 1'b0};
        dbl    = {word, word} << sh;
        rolled = dbl[63:32];
        fit    = (rolled[31:IMM_W] == '0);
        imm8   = rolled[IMM_W-1:0];
    end

endmodule

// File: rtl/operand2_imm_encoder.sv
// Iterative search for a {rot, imm8} encoding of a 32-bit constant, one
// rotation per cycle, optionally retrying with the inverted constant.
module operand2_imm_encoder
    import operand2_pkg::*;
#(
    parameter logic ALLOW_INV = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       value,
    output logic              busy,
    output logic              done,
    output logic              ok,
    output logic              inv,
    output logic [SRC2_W-1:0] src2
);

    enc_state_t       state;
    logic [31:0]      val_q;
    logic [ROT_W-1:0] rot_cnt;
    logic             phase;
    logic [31:0]      word_sel;
    logic             fit;
    logic [IMM_W-1:0] imm8;

    // Phase 1 tests the complemented constant for MVN-style encodings.
    always_comb begin
        word_sel = phase ? ~val_q : val_q;
    end

    rol_fit_check u_fit (
        .word (word_sel),
        .rot  (rot_cnt),
        .fit  (fit),
        .imm8 (imm8)
    );

    // Operand capture; only loaded on accept, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            val_q <= value;
        end
    end

    // Search control: first hit in (phase, rot) order wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ok      <= 1'b0;
            inv     <= 1'b0;
            src2    <= '0;
            rot_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rot_cnt <= '0;
                        phase   <= 1'b0;
                        busy    <= 1'b1;
                        ok      <= 1'b0;
                        inv     <= 1'b0;
                        src2    <= '0;
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (fit) begin
                        src2  <= {rot_cnt, imm8};
                        inv   <= phase;
                        ok    <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (rot_cnt != ROT_W'(ROT_STEPS - 1)) begin
                        rot_cnt <= rot_cnt + ROT_W'(1);
                    end else if (!phase && ALLOW_INV == 1'b1) begin
                        phase   <= 1'b1;
                        rot_cnt <= '0;
                    end else begin
                        ok    <= 1'b0;
                        inv   <= 1'b0;
                        src2  <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand2_imm_encoder.sv
// Directed-vector bench for operand2_imm_encoder, with one instance per
// ALLOW_INV setting sharing the same stimulus.
module tb_operand2_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = 32'h0;

    logic        busy, done, ok, inv;
    logic [11:0] src2;
    logic        busy0, done0, ok0, inv0;
    logic [11:0] src20;

    int errors = 0;
    int checks = 0;

    int          lat, lat0, done_cnt;
    logic        r_ok, r_inv, r_ok0, r_inv0;
    logic [11:0] r_src2, r_src20;

    typedef struct {
        logic [31:0] v;
        int          lat;
        logic        ok;
        logic        inv;
        logic [11:0] src2;
    } vec_t;

    operand2_imm_encoder #(.ALLOW_INV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy), .done(done), .ok(ok), .inv(inv), .src2(src2)
    );

    operand2_imm_encoder #(.ALLOW_INV(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value),
        .busy(busy0), .done(done0), .ok(ok0), .inv(inv0), .src2(src20)
    );

    always #5 clk = ~clk;

    // Pulse start for one accept edge; value is scrambled afterwards.
    task automatic launch(input logic [31:0] v);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 32'h0;
    endtask

    // Watch both instances for a fixed window, recording the first done.
    task automatic watch(input int limit);
        lat = -1; lat0 = -1; done_cnt = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k; r_ok = ok; r_inv = inv; r_src2 = src2;
                end
            end
            if (done0 && lat0 < 0) begin
                lat0 = k; r_ok0 = ok0; r_inv0 = inv0; r_src20 = src20;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", ok); end
        checks++; if (inv !== 1'b0) begin errors++; $display("FAIL reset_inv: got %b want 0", inv); end
        checks++; if (src2 !== 12'h000) begin errors++; $display("FAIL reset_src2: got %h want 000", src2); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_encode();
        vec_t tbl[6] = '{
            '{32'h000000AB,  1, 1'b1, 1'b0, 12'h0AB},
            '{32'hAB000000,  5, 1'b1, 1'b0, 12'h4AB},
            '{32'hC000003F,  2, 1'b1, 1'b0, 12'h1FF},
            '{32'h00000104, 16, 1'b1, 1'b0, 12'hF41},
            '{32'hFFFFFF00, 17, 1'b1, 1'b1, 12'h0FF},
            '{32'h00000000,  1, 1'b1, 1'b0, 12'h000}
        };
        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].v);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enc%0d_busy: got %b want 1", i, busy); end
            watch(40);
            checks++; if (lat != tbl[i].lat) begin errors++; $display("FAIL enc%0d_latency: got %0d want %0d", i, lat, tbl[i].lat); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL enc%0d_done_pulses: got %0d want 1", i, done_cnt); end
            checks++; if (r_ok !== tbl[i].ok) begin errors++; $display("FAIL enc%0d_ok: got %b want %b", i, r_ok, tbl[i].ok); end
            checks++; if (r_inv !== tbl[i].inv) begin errors++; $display("FAIL enc%0d_inv: got %b want %b", i, r_inv, tbl[i].inv); end
            checks++; if (r_src2 !== tbl[i].src2) begin errors++; $display("FAIL enc%0d_src2: got %h want %h", i, r_src2, tbl[i].src2); end
            checks++; if (src2 !== tbl[i].src2) begin errors++; $display("FAIL enc%0d_src2_held: got %h want %h", i, src2, tbl[i].src2); end
        end
    endtask

    task automatic test_no_inv();
        launch(32'hFFFFFF00);
        watch(40);
        checks++; if (lat0 != 16) begin errors++; $display("FAIL noinv_latency: got %0d want 16", lat0); end
        checks++; if (r_ok0 !== 1'b0) begin errors++; $display("FAIL noinv_ok: got %b want 0", r_ok0); end
        checks++; if (r_inv0 !== 1'b0) begin errors++; $display("FAIL noinv_inv: got %b want 0", r_inv0); end
        checks++; if (r_src20 !== 12'h000) begin errors++; $display("FAIL noinv_src2: got %h want 000", r_src20); end
        checks++; if (lat != 17) begin errors++; $display("FAIL inv_side_latency: got %0d want 17", lat); end
        launch(32'hAB000000);
        watch(40);
        checks++; if (lat0 != 5) begin errors++; $display("FAIL noinv_hit_latency: got %0d want 5", lat0); end
        checks++; if (r_src20 !== 12'h4AB) begin errors++; $display("FAIL noinv_hit_src2: got %h want 4AB", r_src20); end
    endtask

    task automatic test_fail_and_ignore();
        launch(32'h00000101);
        @(posedge clk);
        @(posedge clk);
        #1;
        value = 32'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", busy); end
        watch(40);
        checks++; if (lat != 29) begin errors++; $display("FAIL fail_latency: got %0d want 29 (N+32)", lat); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL fail_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (r_ok !== 1'b0) begin errors++; $display("FAIL fail_ok: got %b want 0", r_ok); end
        checks++; if (r_inv !== 1'b0) begin errors++; $display("FAIL fail_inv: got %b want 0", r_inv); end
        checks++; if (r_src2 !== 12'h000) begin errors++; $display("FAIL fail_src2: got %h want 000", r_src2); end
        checks++; if (lat0 != 13) begin errors++; $display("FAIL fail_noinv_latency: got %0d want 13 (N+16)", lat0); end
    endtask

    task automatic test_back_to_back();
        launch(32'h000000AB);
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
        checks++; if (src2 !== 12'h0AB) begin errors++; $display("FAIL b2b_first_src2: got %h want 0AB", src2); end
        value = 32'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_accept_done: got %b want 0", done); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL b2b_accept_ok_cleared: got %b want 0", ok); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b want 1", done); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_second_ok: got %b want 1", ok); end
        checks++; if (src2 !== 12'h000) begin errors++; $display("FAIL b2b_second_src2: got %h want 000", src2); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        launch(32'h00000101);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL rstmid_ok: got %b want 0", ok); end
        checks++; if (src2 !== 12'h000) begin errors++; $display("FAIL rstmid_src2: got %h want 000", src2); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        rst_n = 1'b1;
        watch(40);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_no_inv();
        test_fail_and_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
